// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, ARM condition codes,
// NZCV bit positions, forward selects and the multiplier FSM states.
package exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mulState_t;

    typedef struct packed {
        logic       pcSrc;
        logic       regWrite;
        logic       memtoReg;
        logic       memWrite;
        logic       branch;
        logic       aluSrc;
        logic [1:0] flagWrite;
        logic [2:0] aluControl;
        logic [3:0] cond;
    } ctrl_t;

    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// only the low WIDTH bits of the product are kept.
module iter_mul
    import exec_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    mulState_t        state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand, mplier, acc, partial;

    assign partial = mcand * WIDTH'(mplier[MUL_STEP-1:0]);
    assign product = acc;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state <= MUL_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
        end else begin
            case (state)
                MUL_IDLE: if (start) begin
                    state  <= MUL_RUN;
                    busy   <= 1'b1;
                    count  <= '0;
                    mcand  <= opA;
                    mplier <= opB;
                    acc    <= '0;
                end
                MUL_RUN: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state <= MUL_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                    done  <= 1'b0;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: E pipeline register, forwarding, ALU with NZCV flags,
// ARM condition gating and an iterative multiplier that stalls the pipe.
module exec_stage
    import exec_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 4,
    parameter int MUL_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallE,
    input  logic              flushE,
    input  logic              PCSrcD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        FlagWriteD,
    input  logic [2:0]        ALUControlD,
    input  logic [3:0]        CondD,
    input  logic [WIDTH-1:0]  Rd1D,
    input  logic [WIDTH-1:0]  Rd2D,
    input  logic [WIDTH-1:0]  ExtD,
    input  logic [ADDR_W-1:0] WriteAddrD,
    input  logic [1:0]        forwardAE,
    input  logic [1:0]        forwardBE,
    input  logic [WIDTH-1:0]  ALUResultM,
    input  logic [WIDTH-1:0]  ResultW,
    output logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              BranchTakenE,
    output logic [WIDTH-1:0]  ALUResultE,
    output logic [WIDTH-1:0]  WriteDataE,
    output logic [ADDR_W-1:0] WriteAddrE,
    output logic [3:0]        FlagsE,
    output logic              busyE
);
    ctrl_t            ctrlD, ctrlE;
    logic [WIDTH-1:0] rd1E, rd2E, extE;
    logic [WIDTH-1:0] opA, opB, nonImmOpB, bEff, aluOut, product;
    logic [WIDTH:0]   sum;
    logic isMulE, isSub, isArith, mulBusy, mulDone, mulConsumed, mulStart;
    logic holdE, condEx, resultValid, gateE, carry, overflow;

    assign ctrlD = '{PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
                     FlagWriteD, ALUControlD, CondD};

    assign isMulE = ctrlE.aluControl == ALU_MUL;
    // A MUL holds E from its first cycle until DONE so its controls survive;
    // mulConsumed stops a stalled, already-finished MUL from restarting.
    assign holdE    = stallE | (isMulE & ~mulDone & ~mulConsumed);
    assign mulStart = isMulE & ~mulBusy & ~mulDone & ~mulConsumed & ~flushE;

    always_ff @(posedge clk) begin
        if (reset || flushE) begin
            ctrlE      <= '0;
            rd1E       <= '0;
            rd2E       <= '0;
            extE       <= '0;
            WriteAddrE <= '0;
        end else if (!holdE) begin
            ctrlE      <= ctrlD;
            rd1E       <= Rd1D;
            rd2E       <= Rd2D;
            extE       <= ExtD;
            WriteAddrE <= WriteAddrD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flushE || !holdE) mulConsumed <= 1'b0;
        else if (mulDone)              mulConsumed <= 1'b1;
    end

    always_comb begin
        case (forwardAE)
            FWD_W:   opA = ResultW;
            FWD_M:   opA = ALUResultM;
            default: opA = rd1E;
        endcase
        case (forwardBE)
            FWD_W:   nonImmOpB = ResultW;
            FWD_M:   nonImmOpB = ALUResultM;
            default: nonImmOpB = rd2E;
        endcase
    end

    assign opB        = ctrlE.aluSrc ? extE : nonImmOpB;
    assign WriteDataE = nonImmOpB;

    assign isSub    = ctrlE.aluControl == ALU_SUB;
    assign isArith  = isSub | (ctrlE.aluControl == ALU_ADD);
    assign bEff     = isSub ? ~opB : opB;
    assign sum      = {1'b0, opA} + {1'b0, bEff} + {{WIDTH{1'b0}}, isSub};
    assign carry    = sum[WIDTH];
    assign overflow = (opA[WIDTH-1] == bEff[WIDTH-1]) & (sum[WIDTH-1] != opA[WIDTH-1]);

    always_comb begin
        case (ctrlE.aluControl)
            ALU_ADD, ALU_SUB: aluOut = sum[WIDTH-1:0];
            ALU_AND:          aluOut = opA & opB;
            ALU_ORR:          aluOut = opA | opB;
            ALU_EOR:          aluOut = opA ^ opB;
            ALU_MUL:          aluOut = product;
            default:          aluOut = '0;
        endcase
    end

    iter_mul #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) uMul (
        .clk     (clk),
        .reset   (reset),
        .start   (mulStart),
        .abort   (flushE),
        .opA     (opA),
        .opB     (opB),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (product)
    );

    assign busyE       = mulBusy;
    assign ALUResultE  = aluOut;
    assign condEx      = condPass(ctrlE.cond, FlagsE);
    // A MUL only counts in its DONE cycle, and not if that cycle is flushed.
    assign resultValid = ~isMulE | (mulDone & ~flushE);
    assign gateE       = condEx & resultValid;

    assign RegWriteE    = ctrlE.regWrite & gateE;
    assign MemWriteE    = ctrlE.memWrite & gateE;
    assign PCSrcE       = ctrlE.pcSrc & gateE;
    assign BranchTakenE = ctrlE.branch & gateE;
    assign MemtoRegE    = ctrlE.memtoReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsE <= '0;
        end else if (gateE) begin
            if (ctrlE.flagWrite[1]) begin
                FlagsE[FLAG_N] <= aluOut[WIDTH-1];
                FlagsE[FLAG_Z] <= aluOut == '0;
            end
            if (ctrlE.flagWrite[0] && isArith) begin
                FlagsE[FLAG_C] <= carry;
                FlagsE[FLAG_V] <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: expectations are queued on a scoreboard as
// stimulus is driven and popped when the corresponding output is sampled.
module tb_exec_stage;
    logic        clk = 1'b0;
    logic        reset, stallE, flushE;
    logic        PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
    logic [1:0]  FlagWriteD, forwardAE, forwardBE;
    logic [2:0]  ALUControlD;
    logic [3:0]  CondD, WriteAddrD, WriteAddrE, FlagsE;
    logic [31:0] Rd1D, Rd2D, ExtD, ALUResultM, ResultW, ALUResultE, WriteDataE;
    logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchTakenE, busyE;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_stage #(.WIDTH(32), .ADDR_W(4), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .FlagWriteD(FlagWriteD), .ALUControlD(ALUControlD), .CondD(CondD),
        .Rd1D(Rd1D), .Rd2D(Rd2D), .ExtD(ExtD), .WriteAddrD(WriteAddrD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchTakenE(BranchTakenE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .WriteAddrE(WriteAddrE), .FlagsE(FlagsE), .busyE(busyE)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clearD();
        PCSrcD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; ALUSrcD = 0;
        FlagWriteD = 0; ALUControlD = 0; CondD = 0; WriteAddrD = 0;
        Rd1D = 0; Rd2D = 0; ExtD = 0; forwardAE = 0; forwardBE = 0;
        ALUResultM = 0; ResultW = 0;
    endtask

    task automatic setOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic [1:0] fw, input logic [3:0] cond,
                         input logic [3:0] addr);
        clearD();
        ALUControlD = op; Rd1D = a; Rd2D = b; RegWriteD = rw;
        FlagWriteD = fw; CondD = cond; WriteAddrD = addr;
    endtask

    // Ticks until busyE drops (bounded); counts busy cycles and any write-enable seen.
    task automatic waitMul(output int n, output logic rwSeen);
        logic fin;
        n = 0; rwSeen = 0; fin = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            tick();
            if (busyE) begin
                n++;
                rwSeen |= RegWriteE;
            end else fin = 1;
        end
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [15:0] condMask;
        condMask = 16'hD556;   // pass/fail per cond code with NZCV=1011

        reset = 1; stallE = 0; flushE = 0;
        clearD();
        tick(); tick();
        push("rst_flags", 0);    check(32'(FlagsE));
        push("rst_regwrite", 0); check(32'(RegWriteE));
        push("rst_busy", 0);     check(32'(busyE));
        push("rst_pcsrc", 0);    check(32'(PCSrcE));
        reset = 0;

        // ADD 7 + (-7) sets Z and C
        setOp(3'b000, 32'd7, 32'hFFFF_FFF9, 1, 2'b11, 4'hE, 4'd3);
        tick();
        push("add_zero_result", 0); check(ALUResultE);
        push("add_regwrite", 1);    check(32'(RegWriteE));
        push("add_addr", 3);        check(32'(WriteAddrE));
        clearD();
        tick();
        push("add_flags", 4'b0110); check(32'(FlagsE));

        // SUB with A forwarded from M
        setOp(3'b001, 32'h99, 32'h5, 0, 2'b00, 4'hE, 4'd1);
        forwardAE = 2'b10; ALUResultM = 32'h10;
        tick();
        push("sub_fwdM_result", 32'h0B); check(ALUResultE);
        push("sub_writedata", 32'h5);    check(WriteDataE);

        // ORR with B forwarded from W
        setOp(3'b011, 32'hF0, 32'h77, 0, 2'b00, 4'hE, 4'd1);
        forwardBE = 2'b01; ResultW = 32'h0F;
        tick();
        push("orr_fwdW_result", 32'hFF); check(ALUResultE);
        push("orr_writedata", 32'h0F);   check(WriteDataE);

        // select 11 falls back to register operands
        setOp(3'b010, 32'hFF, 32'h3C, 0, 2'b00, 4'hE, 4'd1);
        forwardAE = 2'b11; forwardBE = 2'b11; ALUResultM = 32'hDEAD; ResultW = 32'hBEEF;
        tick();
        push("and_fwd11_result", 32'h3C); check(ALUResultE);

        // EOR with immediate operand
        setOp(3'b100, 32'hFF, 32'h1234, 0, 2'b00, 4'hE, 4'd1);
        ALUSrcD = 1; ExtD = 32'h0F;
        tick();
        push("eor_imm_result", 32'hF0);  check(ALUResultE);
        push("eor_writedata", 32'h1234); check(WriteDataE);

        // NE with Z=1 fails; MemtoReg passes through ungated
        setOp(3'b000, 32'd1, 32'd1, 1, 2'b11, 4'h1, 4'd2);
        MemtoRegD = 1;
        tick();
        push("ne_regwrite", 0);  check(32'(RegWriteE));
        push("ne_memtoreg", 1);  check(32'(MemtoRegE));

        // EQ passes; all gated controls come through
        setOp(3'b000, 32'd1, 32'd2, 1, 2'b00, 4'h0, 4'd2);
        MemWriteD = 1; BranchD = 1; PCSrcD = 1;
        tick();
        push("ne_flags_kept", 4'b0110); check(32'(FlagsE));
        push("eq_regwrite", 1);     check(32'(RegWriteE));
        push("eq_memwrite", 1);     check(32'(MemWriteE));
        push("eq_branchtaken", 1);  check(32'(BranchTakenE));
        push("eq_pcsrc", 1);        check(32'(PCSrcE));

        // signed overflow on SUB: 0x80000000 - 1
        setOp(3'b001, 32'h8000_0000, 32'd1, 0, 2'b11, 4'hE, 4'd4);
        tick();
        push("sub_ovf_result", 32'h7FFF_FFFF); check(ALUResultE);
        // logic op writes N,Z only
        setOp(3'b010, 32'hF000_0000, 32'hFFFF_FFFF, 0, 2'b11, 4'hE, 4'd4);
        tick();
        push("sub_ovf_flags", 4'b0011);      check(32'(FlagsE));
        push("and_result", 32'hF000_0000);   check(ALUResultE);

        for (int i = 0; i < 16; i++) begin
            setOp(3'b000, 32'd0, 32'd0, 1, 2'b00, 4'(i), 4'd9);
            tick();
            push("cond_table", 32'(condMask[i])); check(32'(RegWriteE));
        end
        push("and_flags", 4'b1011); check(32'(FlagsE));

        // stall holds E, flush loads a bubble
        setOp(3'b000, 32'd1, 32'd2, 1, 2'b00, 4'hE, 4'd1);
        tick();
        push("pre_stall_result", 3); check(ALUResultE);
        setOp(3'b000, 32'd10, 32'd20, 1, 2'b00, 4'hE, 4'd1);
        stallE = 1;
        tick();
        push("stall_hold", 3); check(ALUResultE);
        stallE = 0;
        tick();
        push("stall_release", 30); check(ALUResultE);
        flushE = 1;
        tick();
        flushE = 0;
        push("flush_regwrite", 0); check(32'(RegWriteE));
        push("flush_result", 0);   check(ALUResultE);

        // MUL 0x1234 * 0x10; MUL must leave C,V alone even with FlagWrite=11
        setOp(3'b101, 32'h1234, 32'h10, 1, 2'b11, 4'hE, 4'd5);
        tick();
        clearD();
        push("mul_start_regwrite", 0); check(32'(RegWriteE));
        waitMul(n, seen);
        push("mul_busy_cycles", 8);      check(32'(n));
        push("mul_busy_regwrite", 0);    check(32'(seen));
        push("mul_result", 32'h12340);   check(ALUResultE);
        push("mul_done_regwrite", 1);    check(32'(RegWriteE));
        push("mul_done_addr", 5);        check(32'(WriteAddrE));
        tick();
        push("mul_after_regwrite", 0);   check(32'(RegWriteE));
        push("mul_flags", 4'b0011);      check(32'(FlagsE));

        // back-to-back MULs
        setOp(3'b101, 32'd3, 32'd5, 1, 2'b00, 4'hE, 4'd6);
        tick();
        setOp(3'b101, 32'd7, 32'd6, 1, 2'b00, 4'hE, 4'd7);
        waitMul(n, seen);
        push("b2b_first_result", 15); check(ALUResultE);
        push("b2b_first_addr", 6);    check(32'(WriteAddrE));
        tick();
        push("b2b_second_loaded", 7); check(32'(WriteAddrE));
        tick();
        push("b2b_second_busy", 1);   check(32'(busyE));
        clearD();
        waitMul(n, seen);
        push("b2b_second_result", 42); check(ALUResultE);
        push("b2b_second_regwrite", 1); check(32'(RegWriteE));
        tick();

        // flush in the third RUN cycle aborts; result would have set N
        setOp(3'b101, 32'h8000_0000, 32'd3, 1, 2'b11, 4'hE, 4'd5);
        tick();
        clearD();
        tick(); tick(); tick();
        flushE = 1;
        tick();
        flushE = 0;
        push("flush_mul_busy", 0); check(32'(busyE));
        seen = 0;
        repeat (12) begin
            tick();
            seen |= RegWriteE | busyE;
        end
        push("flush_mul_quiet", 0);    check(32'(seen));
        push("flush_mul_flags", 4'b0011); check(32'(FlagsE));

        // reset in the middle of RUN
        setOp(3'b101, 32'd5, 32'd5, 1, 2'b11, 4'hE, 4'd2);
        PCSrcD = 1; MemWriteD = 1; BranchD = 1; MemtoRegD = 1;
        tick();
        tick(); tick();
        push("pre_reset_busy", 1); check(32'(busyE));
        reset = 1;
        tick();
        push("rstrun_busy", 0);     check(32'(busyE));
        push("rstrun_flags", 0);    check(32'(FlagsE));
        push("rstrun_regwrite", 0); check(32'(RegWriteE));
        push("rstrun_memwrite", 0); check(32'(MemWriteE));
        push("rstrun_pcsrc", 0);    check(32'(PCSrcE));
        push("rstrun_branch", 0);   check(32'(BranchTakenE));
        push("rstrun_memtoreg", 0); check(32'(MemtoRegE));
        clearD();
        reset = 0;
        tick(); tick();
        push("post_reset_busy", 0); check(32'(busyE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width.
REQ-002 SHALL have parameter ADDR_W, default 4: register-address width.
REQ-003 SHALL have parameter MUL_STEP, default 4: multiplier bits retired per cycle; must divide WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- stallE  in  1  hold E register
- flushE  in  1  load bubble into E register
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decode controls
- FlagWriteD  in  2  [1] NZ write, [0] CV write
- ALUControlD  in  3  op: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL
- CondD  in  4  ARM condition field
- Rd1D, Rd2D, ExtD  in  WIDTH  register operands, extended immediate
- WriteAddrD  in  ADDR_W  destination
- forwardAE, forwardBE  in  2  00 reg, 01 ResultW, 10 ALUResultM
- ALUResultM, ResultW  in  WIDTH  forwarding sources
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchTakenE  out  1  condition-gated controls
- ALUResultE, WriteDataE  out  WIDTH  result, forwarded store data
- WriteAddrE  out  ADDR_W  destination
- FlagsE  out  4  NZCV register
- busyE  out  1  multiply in progress; stall request to hazard unit

Function
REQ-005 SHALL register all D inputs into E register when ~stallE & ~busyE; when flushE=1 SHALL load all-zero controls (bubble), with priority over stall and busy.
REQ-006 SHALL select OpA/nonImmOpB via forward mux (11 treated as 00); OpB = ExtE if ALUSrcE else nonImmOpB; WriteDataE = nonImmOpB.
REQ-007 SHALL compute ADD/SUB/AND/ORR/EOR combinationally; SUB = OpA + ~OpB + 1; C = carry-out, V = signed overflow.
REQ-008 SHALL evaluate CondE against FlagsE (pre-update): EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 passes.
REQ-009 SHALL gate RegWriteE, MemWriteE, PCSrcE by CondEx; BranchTakenE = BranchE & CondEx; MemtoRegE ungated.
REQ-010 SHALL update FlagsE at clock edge only when CondEx & ~busyE: NZ if FlagWriteE[1], CV if FlagWriteE[0]; logic ops and MUL never change C,V.
REQ-011 MUL SHALL use FSM IDLE->RUN->DONE: IDLE with MUL in E -> RUN, latching OpA/OpB; RUN lasts WIDTH/MUL_STEP cycles, busyE=1; DONE lasts 1 cycle, busyE=0, ALUResultE = low WIDTH bits of product; DONE->IDLE.
REQ-012 While busyE=1, RegWriteE, MemWriteE, PCSrcE, BranchTakenE SHALL be 0 and E register SHALL hold regardless of stallE.
REQ-013 flushE during RUN/DONE SHALL abort to IDLE, no result, no flag update.
REQ-014 Non-MUL ops SHALL have zero added latency (result in same cycle as E register load).
REQ-015 Back-to-back MUL SHALL start the second in the cycle after DONE.

Reset
REQ-016 reset SHALL clear E register to bubble, FlagsE=0000, FSM=IDLE, counter=0; all gated outputs 0, busyE=0.
REQ-017 reset mid-RUN SHALL abort the multiply in the same edge; reset has priority over flush and stall.

Structure
REQ-018 SHALL place ALU op codes, condition codes, NZCV bit indices, and forward-select codes in shared package exec_pkg.
REQ-019 SHALL implement the multiplier as sub-module iter_mul (start, operands, busy, done, product).

Verification
REQ-020 ADD 7+(-7), FlagWriteD=11 -> ALUResultE=0, next FlagsE=0110 (Z,C).
REQ-021 forwardAE=10, ALUResultM=0x10, Rd2D=0x5, SUB -> ALUResultE=0x0B.
REQ-022 FlagsE Z=1, CondD=NE, RegWriteD=1 -> RegWriteE=0, FlagsE unchanged.
REQ-023 MUL 0x1234*0x10 (WIDTH=32, MUL_STEP=4) -> busyE=1 for 8 cycles, then ALUResultE=0x12340, RegWriteE=1 one cycle.
REQ-024 flushE asserted cycle 3 of RUN -> busyE=0 next cycle, no RegWriteE pulse.
REQ-025 reset during RUN -> next cycle busyE=0, FlagsE=0000, all controls 0.
